// File: rtl/adc_spi_capture.sv
// AD7980 capture: raises CNV, clocks 16 SCLK pulses and latches one 16-bit sample per 35-channel frame.
// Optional feature macro ADC_TWOS_COMP_EN: output two's complement instead of straight binary.
module adc_spi_capture #(
   parameter logic [31:0] ms_wait    = 32'd99,
   parameter logic [31:0] ms_clk1_a  = 32'd100,
   parameter logic [31:0] ms_clk11_a = 32'd140
) (
   input  logic        dataclk,
   input  logic        reset,
   input  logic [31:0] main_state,
   input  logic [5:0]  channel,
   input  logic        ADC_en,
   input  logic        ADC_DOUT,
   output logic        ADC_CNV,
   output logic        ADC_SCLK,
   output logic [15:0] ADC_register,
   output logic        ADC_valid
);

   typedef enum logic {
      FRAME_IDLE   = 1'b0,
      FRAME_ACTIVE = 1'b1
   } frame_state_t;

   frame_state_t state_r;
   frame_state_t state_s;
   logic         en_q_r;
   logic         en_q_s;
   logic [15:0]  shift_r;
   logic [15:0]  shift_s;
   logic         cnv_s;
   logic         sclk_s;
   logic         valid_s;
   logic [15:0]  register_s;
   logic [3:0]   bit_idx_s;

   function automatic logic [15:0] format_sample(input logic [15:0] raw);
`ifdef ADC_TWOS_COMP_EN
      return {~raw[15], raw[14:0]};
`else
      return raw;
`endif
   endfunction

   // Channels 3..18 map to bits 15..0; (18 - channel) mod 16 equals (2 - channel[3:0]) mod 16.
   assign bit_idx_s = 4'd2 - channel[3:0];

   // Next-state and output decode; a frame is only strobed if channel 0 was seen without an intervening ms_wait.
   always_comb begin
      state_s    = state_r;
      en_q_s     = en_q_r;
      shift_s    = shift_r;
      cnv_s      = ADC_CNV;
      sclk_s     = ADC_SCLK;
      register_s = ADC_register;
      valid_s    = 1'b0;
      if (main_state == ms_wait) begin
         cnv_s   = 1'b0;
         sclk_s  = 1'b0;
         shift_s = 16'h0000;
         state_s = FRAME_IDLE;
      end else if (main_state == ms_clk1_a) begin
         case (channel) inside
            6'd0: begin
               en_q_s  = ADC_en;
               cnv_s   = ADC_en;
               shift_s = 16'h0000;
               state_s = FRAME_ACTIVE;
            end
            6'd2: begin
               cnv_s = 1'b0;
            end
            [6'd3:6'd18]: begin
               if (en_q_r && (state_r == FRAME_ACTIVE)) begin
                  shift_s[bit_idx_s] = ADC_DOUT;
                  sclk_s             = 1'b1;
               end else begin
                  sclk_s = ADC_SCLK;
               end
            end
            6'd19: begin
               if (state_r == FRAME_ACTIVE) begin
                  register_s = en_q_r ? format_sample(shift_r) : 16'h0000;
                  valid_s    = 1'b1;
                  state_s    = FRAME_IDLE;
               end else begin
                  register_s = ADC_register;
               end
            end
            [6'd20:6'd34]: begin
               cnv_s  = 1'b0;
               sclk_s = 1'b0;
            end
            default: begin
               valid_s = 1'b0;
            end
         endcase
      end else if (main_state == ms_clk11_a) begin
         sclk_s = 1'b0;
      end else begin
         valid_s = 1'b0;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge dataclk) begin
      if (reset) begin
         state_r      <= FRAME_IDLE;
         en_q_r       <= 1'b0;
         shift_r      <= 16'h0000;
         ADC_CNV      <= 1'b0;
         ADC_SCLK     <= 1'b0;
         ADC_register <= 16'h0000;
         ADC_valid    <= 1'b0;
      end else begin
         state_r      <= state_s;
         en_q_r       <= en_q_s;
         shift_r      <= shift_s;
         ADC_CNV      <= cnv_s;
         ADC_SCLK     <= sclk_s;
         ADC_register <= register_s;
         ADC_valid    <= valid_s;
      end
   end

endmodule

// File: tb/tb_adc_spi_capture.sv
// Scoreboard bench for adc_spi_capture: sequencer stimulus, behavioural AD7980 model, queue-based result checking.
module tb_adc_spi_capture;

   localparam logic [31:0] MS_WAIT    = 32'd99;
   localparam logic [31:0] MS_CLK1_A  = 32'd100;
   localparam logic [31:0] MS_FILL_A  = 32'd120;
   localparam logic [31:0] MS_CLK11_A = 32'd140;
   localparam logic [31:0] MS_FILL_B  = 32'd141;
   localparam int          SLOT_CYCLES = 4;
   localparam int          NONE = -1;

   logic        dataclk = 1'b0;
   logic        reset;
   logic [31:0] main_state;
   logic [5:0]  channel;
   logic        ADC_en;
   logic        ADC_DOUT = 1'b0;
   logic        ADC_CNV;
   logic        ADC_SCLK;
   logic [15:0] ADC_register;
   logic        ADC_valid;

   int checks = 0;
   int passes = 0;
   int cycle = 0;
   int cnv_cycles;
   int sclk_pulses;
   logic sclk_prev;
   logic [15:0] model_reg = 16'h0000;
   logic [15:0] exp_q[$];
   int strobe_cycles[$];

   adc_spi_capture dut (
      .dataclk(dataclk), .reset(reset), .main_state(main_state), .channel(channel),
      .ADC_en(ADC_en), .ADC_DOUT(ADC_DOUT), .ADC_CNV(ADC_CNV), .ADC_SCLK(ADC_SCLK),
      .ADC_register(ADC_register), .ADC_valid(ADC_valid)
   );

   always #5 dataclk = ~dataclk;
   always @(posedge dataclk) cycle <= cycle + 1;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual === expected) passes++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
   endtask

   function automatic logic [15:0] sample_value(input logic [15:0] word);
`ifdef ADC_TWOS_COMP_EN
      return word + 16'h8000;
`else
      return word;
`endif
   endfunction

   // AD7980 model: MSB appears after CNV falls, each SCLK fall shifts out the next bit
   logic [15:0] adc_word = 16'h0000;
   int   bit_idx = 0;
   logic cnv_seen = 1'b0;
   logic sclk_seen = 1'b0;
   always @(negedge dataclk) begin
      if (cnv_seen && !ADC_CNV) begin
         bit_idx  = 15;
         ADC_DOUT = adc_word[15];
      end else if (sclk_seen && !ADC_SCLK && bit_idx > 0) begin
         bit_idx  = bit_idx - 1;
         ADC_DOUT = adc_word[bit_idx];
      end
      cnv_seen  = ADC_CNV;
      sclk_seen = ADC_SCLK;
   end

   // Monitor: every strobe pops one expected sample
   logic valid_prev = 1'b0;
   always @(negedge dataclk) begin
      if (ADC_valid) begin
         strobe_cycles.push_back(cycle);
         check("valid_width", {31'd0, valid_prev}, 32'd0);
         if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_valid: ADC_valid=1 ADC_register=%h, no sample expected (t=%0t)",
                     ADC_register, $time);
         end else begin
            check("adc_register", {16'd0, ADC_register}, {16'd0, exp_q.pop_front()});
         end
      end
      valid_prev = ADC_valid;
   end

   task automatic step(input logic [31:0] ms, input int ch);
      main_state = ms;
      channel    = 6'(ch);
      @(posedge dataclk);
      #1;
      if (ADC_CNV) cnv_cycles++;
      if (ADC_SCLK && !sclk_prev) sclk_pulses++;
      sclk_prev = ADC_SCLK;
   endtask

   task automatic run_frame(input logic [15:0] word, input logic en0, input logic en_mid,
                            input int abort_ch, input int reset_ch);
      logic live;
      live        = 1'b1;
      adc_word    = word;
      ADC_en      = en0;
      cnv_cycles  = 0;
      sclk_pulses = 0;
      sclk_prev   = ADC_SCLK;
      for (int ch = 0; ch < 35; ch++) begin
         if (ch == 5) ADC_en = en_mid;
         if (ch == abort_ch) begin
            repeat (3) step(MS_WAIT, ch);
            check("abort_sclk", {31'd0, ADC_SCLK}, 32'd0);
            check("abort_cnv", {31'd0, ADC_CNV}, 32'd0);
            check("abort_register", {16'd0, ADC_register}, {16'd0, model_reg});
            return;
         end
         if (ch == 19 && live) begin
            model_reg = en0 ? sample_value(word) : 16'h0000;
            exp_q.push_back(model_reg);
         end
         reset = (ch == reset_ch);
         step(MS_CLK1_A, ch);
         if (ch == reset_ch) begin
            reset     = 1'b0;
            live      = 1'b0;
            model_reg = 16'h0000;
            check("reset_cnv", {31'd0, ADC_CNV}, 32'd0);
            check("reset_sclk", {31'd0, ADC_SCLK}, 32'd0);
            check("reset_register", {16'd0, ADC_register}, 32'd0);
            check("reset_valid", {31'd0, ADC_valid}, 32'd0);
         end
         step(MS_FILL_A, ch);
         step(MS_CLK11_A, ch);
         step(MS_FILL_B, ch);
      end
      if (live) begin
         check("cnv_high_cycles", cnv_cycles, en0 ? 2 * SLOT_CYCLES : 0);
         check("sclk_pulses", sclk_pulses, en0 ? 16 : 0);
      end
      check("register_hold", {16'd0, ADC_register}, {16'd0, model_reg});
   endtask

   initial begin
      reset      = 1'b1;
      main_state = MS_WAIT;
      channel    = 6'd0;
      ADC_en     = 1'b0;
      repeat (3) @(posedge dataclk);
      #1;
      check("rst_cnv", {31'd0, ADC_CNV}, 32'd0);
      check("rst_sclk", {31'd0, ADC_SCLK}, 32'd0);
      check("rst_register", {16'd0, ADC_register}, 32'd0);
      check("rst_valid", {31'd0, ADC_valid}, 32'd0);
      reset = 1'b0;
      repeat (2) step(MS_WAIT, 0);

      run_frame(16'hA5C3, 1'b1, 1'b1, NONE, NONE);
      run_frame(16'h8000, 1'b1, 1'b1, NONE, NONE);
      run_frame(16'h0000, 1'b1, 1'b1, NONE, NONE);
      run_frame(16'h7E81, 1'b0, 1'b1, NONE, NONE);
      run_frame(16'h5A5A, 1'b1, 1'b1, NONE, 10);
      run_frame(16'h1234, 1'b1, 1'b1, NONE, NONE);
      run_frame(16'hC3C3, 1'b1, 1'b1, 12, NONE);

      strobe_cycles.delete();
      run_frame(16'hFFFF, 1'b1, 1'b1, NONE, NONE);
      run_frame(16'h0001, 1'b1, 1'b1, NONE, NONE);
      check("b2b_strobe_count", strobe_cycles.size(), 2);
      if (strobe_cycles.size() == 2)
         check("b2b_strobe_spacing", strobe_cycles[1] - strobe_cycles[0], 35 * SLOT_CYCLES);

      for (int i = 0; i < 12; i++) begin
         logic [15:0] word;
         logic        en0;
         logic        en_mid;
         int          abort_ch;
         word     = 16'($urandom);
         en0      = ($urandom_range(0, 3) != 0);
         en_mid   = 1'($urandom);
         abort_ch = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 18)) : NONE;
         run_frame(word, en0, en_mid, abort_ch, NONE);
      end

      repeat (4) step(MS_WAIT, 0);
      check("pending_samples", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
